hit_resolver: RTL and testbench

Combat resolution stage downstream of the two `player` instances. Each cycle it samples both players' state codes and hit/hurt boxes, detects qualifying hits, and maintains per-player health, hit pulses and hitstun timers. A match-level FSM declares KO, winner and round end for the renderer and HUD.

---
 rtl/hit_resolver.sv | 130 +++++++++++++
 tb/tb_hit_resolver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hit_resolver.sv
// hit_resolver: hit detection, health/stun tracking and match FSM (FIGHT/KO_HOLD/OVER).
// Optional HIT_RESOLVER_INVULN_EN adds a post-hit invulnerability window.
module hit_resolver #(
  parameter int HEALTH_W      = 4,
  parameter int MAX_HEALTH    = 10,
  parameter int DAMAGE        = 2,
  parameter int STUN_CYCLES   = 8,
  parameter int KO_CYCLES     = 30,
  parameter int INVULN_CYCLES = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          p1_state,
  input  logic [3:0]          p2_state,
  input  logic [9:0]          p1_hit_x1,
  input  logic [9:0]          p1_hit_x2,
  input  logic [9:0]          p1_hit_y1,
  input  logic [9:0]          p1_hit_y2,
  input  logic [9:0]          p2_hit_x1,
  input  logic [9:0]          p2_hit_x2,
  input  logic [9:0]          p2_hit_y1,
  input  logic [9:0]          p2_hit_y2,
  input  logic [9:0]          p1_hurt_x1,
  input  logic [9:0]          p1_hurt_x2,
  input  logic [9:0]          p1_hurt_y1,
  input  logic [9:0]          p1_hurt_y2,
  input  logic [9:0]          p2_hurt_x1,
  input  logic [9:0]          p2_hurt_x2,
  input  logic [9:0]          p2_hurt_y1,
  input  logic [9:0]          p2_hurt_y2,
  input  logic                new_round,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_hit,
  output logic                p2_hit,
  output logic                p1_stun,
  output logic                p2_stun,
  output logic [1:0]          winner,
  output logic                ko,
  output logic                round_over
);
  localparam int SW = $clog2(STUN_CYCLES + 1);
  localparam int KW = $clog2(KO_CYCLES + 1);
  typedef enum logic [1:0] {FIGHT, KO_HOLD, OVER} state_t;
  state_t state, state_n;
  logic [SW-1:0] s1, s2;
  logic [KW-1:0] kcnt;
  logic land1, land2, ok1, ok2, a12, a21, restart;
  logic [HEALTH_W-1:0] h1n, h2n;
  function automatic logic ov(input logic [9:0] a1, a2, b1, b2);
    logic [9:0] alo, ahi, blo, bhi;
    alo = a1 < a2 ? a1 : a2;
    ahi = a1 < a2 ? a2 : a1;
    blo = b1 < b2 ? b1 : b2;
    bhi = b1 < b2 ? b2 : b1;
    return alo <= bhi && blo <= ahi;
  endfunction
  function automatic logic [HEALTH_W-1:0] dmg(input logic [HEALTH_W-1:0] h);
    return h > HEALTH_W'(DAMAGE) ? h - HEALTH_W'(DAMAGE) : '0;
  endfunction
  // a12: P1 lands on P2; a21: P2 lands on P1
  assign a12 = state == FIGHT && p1_state == 4'd4 && !land1 && ok2 &&
               ov(p1_hit_x1, p1_hit_x2, p2_hurt_x1, p2_hurt_x2) &&
               ov(p1_hit_y1, p1_hit_y2, p2_hurt_y1, p2_hurt_y2);
  assign a21 = state == FIGHT && p2_state == 4'd4 && !land2 && ok1 &&
               ov(p2_hit_x1, p2_hit_x2, p1_hurt_x1, p1_hurt_x2) &&
               ov(p2_hit_y1, p2_hit_y2, p1_hurt_y1, p1_hurt_y2);
  assign h1n = a21 ? dmg(p1_health) : p1_health;
  assign h2n = a12 ? dmg(p2_health) : p2_health;
  assign restart = state == OVER && new_round;
  assign p1_stun = s1 != '0;
  assign p2_stun = s2 != '0;
  assign ko = state != FIGHT;
  assign round_over = state == OVER;
  always_comb begin
    state_n = state;
    case (state)
      FIGHT:   state_n = (h1n == '0 || h2n == '0) ? KO_HOLD : FIGHT;
      KO_HOLD: state_n = kcnt == '0 ? OVER : KO_HOLD;
      OVER:    state_n = new_round ? FIGHT : OVER;
      default: state_n = FIGHT;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FIGHT;
      p1_health <= HEALTH_W'(MAX_HEALTH);
      p2_health <= HEALTH_W'(MAX_HEALTH);
      {p1_hit, p2_hit, land1, land2} <= '0;
      {s1, s2} <= '0;
      winner <= 2'b00;
      kcnt <= KW'(KO_CYCLES - 1);
    end else begin
      state <= state_n;
      p1_hit <= a21;
      p2_hit <= a12;
      kcnt <= state == KO_HOLD ? kcnt - 1'b1 : KW'(KO_CYCLES - 1);
      if (restart) begin
        p1_health <= HEALTH_W'(MAX_HEALTH);
        p2_health <= HEALTH_W'(MAX_HEALTH);
        {land1, land2} <= '0;
        {s1, s2} <= '0;
        winner <= 2'b00;
      end else begin
        p1_health <= h1n;
        p2_health <= h2n;
        s1 <= a21 ? SW'(STUN_CYCLES) : s1 - SW'(s1 != '0);
        s2 <= a12 ? SW'(STUN_CYCLES) : s2 - SW'(s2 != '0);
        land1 <= a12 | (land1 & p1_state > 4'd2);
        land2 <= a21 | (land2 & p2_state > 4'd2);
        if (state == FIGHT && state_n == KO_HOLD) winner <= {h1n == '0, h2n == '0};
      end
    end
`ifdef HIT_RESOLVER_INVULN_EN
  localparam int IW = $clog2(INVULN_CYCLES + 1);
  logic [IW-1:0] i1, i2;
  assign ok1 = i1 == '0;
  assign ok2 = i2 == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {i1, i2} <= '0;
    else if (restart) {i1, i2} <= '0;
    else begin
      i1 <= a21 ? IW'(INVULN_CYCLES) : i1 - IW'(i1 != '0);
      i2 <= a12 ? IW'(INVULN_CYCLES) : i2 - IW'(i2 != '0);
    end
`else
  assign ok1 = 1'b1;
  assign ok2 = 1'b1;
`endif
endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: randomized + directed scoreboard bench against a frame-level reference model.
module tb_hit_resolver;
  localparam int HW = 4, MAXH = 10, DMG = 2, STUN = 8, KOC = 30, INV = 12;
  logic clk = 0, rst = 0, nr = 0;
  logic [3:0] s1 = 0, s2 = 0;
  logic [9:0] b1[8], b2[8];
  logic [HW-1:0] h1o, h2o;
  logic hit1, hit2, st1o, st2o, koo, roo;
  logic [1:0] wo;
  hit_resolver #(.HEALTH_W(HW), .MAX_HEALTH(MAXH), .DAMAGE(DMG), .STUN_CYCLES(STUN),
                 .KO_CYCLES(KOC), .INVULN_CYCLES(INV)) dut (
    .clk(clk), .rst(rst), .p1_state(s1), .p2_state(s2),
    .p1_hit_x1(b1[0]), .p1_hit_x2(b1[1]), .p1_hit_y1(b1[2]), .p1_hit_y2(b1[3]),
    .p2_hit_x1(b2[0]), .p2_hit_x2(b2[1]), .p2_hit_y1(b2[2]), .p2_hit_y2(b2[3]),
    .p1_hurt_x1(b1[4]), .p1_hurt_x2(b1[5]), .p1_hurt_y1(b1[6]), .p1_hurt_y2(b1[7]),
    .p2_hurt_x1(b2[4]), .p2_hurt_x2(b2[5]), .p2_hurt_y1(b2[6]), .p2_hurt_y2(b2[7]),
    .new_round(nr), .p1_health(h1o), .p2_health(h2o), .p1_hit(hit1), .p2_hit(hit2),
    .p1_stun(st1o), .p2_stun(st2o), .winner(wo), .ko(koo), .round_over(roo));
  always #5 clk = ~clk;
  typedef struct {int h1, h2, hit1, hit2, st1, st2, w, ko, ro;} exp_t;
  exp_t exq[$];
  int cmp = 0, bad = 0;
  // model: phase 0 fighting, 1 KO hold, 2 round over
  int mh1, mh2, mst1, mst2, mi1, mi2, mw, ph, kleft;
  bit ml1, ml2;
  task automatic chk(string n, input logic [31:0] a, input int e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic int mn(int a, int b); return a < b ? a : b; endfunction
  function automatic int mx(int a, int b); return a > b ? a : b; endfunction
  function automatic bit span(int a1, int a2, int c1, int c2);
    return mx(mn(a1, a2), mn(c1, c2)) <= mn(mx(a1, a2), mx(c1, c2));
  endfunction
  task automatic model_reset();
    mh1 = MAXH; mh2 = MAXH; mst1 = 0; mst2 = 0; mi1 = 0; mi2 = 0;
    mw = 0; ph = 0; kleft = 0; ml1 = 0; ml2 = 0;
  endtask
  task automatic predict();
    bit q12, q21;
    exp_t e;
    q12 = ph == 0 && s1 == 4 && !ml1 && span(b1[0], b1[1], b2[4], b2[5]) && span(b1[2], b1[3], b2[6], b2[7]);
    q21 = ph == 0 && s2 == 4 && !ml2 && span(b2[0], b2[1], b1[4], b1[5]) && span(b2[2], b2[3], b1[6], b1[7]);
`ifdef HIT_RESOLVER_INVULN_EN
    q12 = q12 && mi2 == 0;
    q21 = q21 && mi1 == 0;
`endif
    if (ph == 2 && nr) begin
      model_reset();
    end else begin
      mst1 = q21 ? STUN : mx(mst1 - 1, 0);
      mst2 = q12 ? STUN : mx(mst2 - 1, 0);
      mi1 = q21 ? INV : mx(mi1 - 1, 0);
      mi2 = q12 ? INV : mx(mi2 - 1, 0);
      if (q21) mh1 = mx(mh1 - DMG, 0);
      if (q12) mh2 = mx(mh2 - DMG, 0);
      if (s1 < 3) ml1 = 0;
      if (s2 < 3) ml2 = 0;
      if (q12) ml1 = 1;
      if (q21) ml2 = 1;
      if (ph == 1) begin
        kleft--;
        if (kleft == 0) ph = 2;
      end else if (ph == 0 && (mh1 == 0 || mh2 == 0)) begin
        ph = 1; kleft = KOC;
        mw = (mh1 == 0 ? 2 : 0) + (mh2 == 0 ? 1 : 0);
      end
    end
    e = '{mh1, mh2, q21, q12, mst1 > 0, mst2 > 0, mw, ph != 0, ph == 2};
    exq.push_back(e);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst && exq.size() > 0) begin
      e = exq.pop_front();
      chk("p1_health", h1o, e.h1);
      chk("p2_health", h2o, e.h2);
      chk("p1_hit", hit1, e.hit1);
      chk("p2_hit", hit2, e.hit2);
      chk("p1_stun", st1o, e.st1);
      chk("p2_stun", st2o, e.st2);
      chk("winner", wo, e.w);
      chk("ko", koo, e.ko);
      chk("round_over", roo, e.ro);
    end
  end
  task automatic set_geo(int m);
    int g1[8], g2[8];
    g1 = '{247, 323, 194, 227, 240, 180, 170, 320};
    g2 = '{260, 230, 194, 227, 366, 317, 170, 320};
    if (m == 1) begin g2[4] = 457; g2[5] = 506; end
    for (int i = 0; i < 8; i++) begin
      b1[i] = (m == 2) ? 10'($urandom_range(150, 400)) : 10'(g1[i]);
      b2[i] = (m == 2) ? 10'($urandom_range(150, 400)) : 10'(g2[i]);
    end
  endtask
  task automatic cyc(int a, int b, bit n = 0);
    s1 = 4'(a); s2 = 4'(b); nr = n;
    predict();
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2 rst = 0;
    #1;
    chk("rst_p1_health", h1o, MAXH);
    chk("rst_p2_health", h2o, MAXH);
    chk("rst_hits", {hit1, hit2}, 0);
    chk("rst_stuns", {st1o, st2o}, 0);
    chk("rst_winner", wo, 0);
    chk("rst_ko", koo, 0);
    chk("rst_round_over", roo, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask
  function automatic int rnd_state();
    int v = $urandom_range(0, 7);
    return v > 5 ? 4 : v;
  endfunction
  initial begin
    set_geo(0);
    model_reset();
    @(negedge clk);
    do_reset();
    cyc(3, 0); cyc(4, 0); cyc(4, 0);
    repeat (10) cyc(0, 0);
    set_geo(1);
    cyc(3, 0); cyc(4, 0); cyc(0, 0);
    set_geo(0);
    repeat (3) begin cyc(4, 4); cyc(0, 0); end
    cyc(0, 4); cyc(0, 0);
    cyc(4, 4);
    repeat (5) cyc(0, 0);
    cyc(0, 0, 1);
    repeat (30) cyc(0, 0);
    cyc(0, 0, 1);
    cyc(0, 0);
    repeat (5) begin cyc(4, 0); cyc(0, 0); end
    repeat (3) cyc(0, 0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) set_geo($urandom_range(0, 2));
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(rnd_state(), rnd_state(), $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    chk("scoreboard_drain", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
